// File: rtl/sinc3_pkg.sv
// sinc3_pkg: shared constants and sizing helpers for the sinc3 (third-order
// CIC) decimation filter.
//   acc_w(log2_osr)            - width of every integrator, comb and delay
//   shift_amt(log2_osr, out_w) - right shift that maps the CIC gain onto OUT_W
//   X_POS / X_NEG              - the value each modulator bit represents
`timescale 1ns/1ps
package sinc3_pkg;

    localparam int LOG2_OSR_DEF = 6;
    localparam int OUT_W_DEF    = 16;

    // A modulator bit of 1 stands for +1 and a bit of 0 for -1.
    localparam int X_POS = 1;
    localparam int X_NEG = -1;

    // The CIC gain is OSR^3, so an input of +-1 needs 3*log2(OSR) bits plus
    // sign, plus one bit of headroom for the full-scale positive code.
    function automatic int acc_w(input int log2_osr);
        return 3 * log2_osr + 2;
    endfunction

    function automatic int shift_amt(input int log2_osr, input int out_w);
        return 3 * log2_osr + 1 - out_w;
    endfunction

endpackage

// File: rtl/sinc3_decimator_if.sv
// sinc3_decimator_if: bitstream input and PCM output of the sinc3 decimator.
//   bit_in    - modulator bit (1 = +1, 0 = -1)
//   in_valid  - bit_in is consumed on each rising clock edge where this is 1
//   out_data  - decimated signed sample, held between strobes
//   out_valid - one-cycle strobe marking a new out_data
//   out_sat   - qualified by out_valid; the sample was clipped
// master: the bitstream source / sample consumer. slave: the decimator.
`timescale 1ns/1ps
interface sinc3_decimator_if
    import sinc3_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
);
    logic                    bit_in;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_sat;

    modport master (
        output bit_in, in_valid,
        input  out_data, out_valid, out_sat
    );

    modport slave (
        input  bit_in, in_valid,
        output out_data, out_valid, out_sat
    );
endinterface

// File: rtl/sinc3_integrator.sv
// sinc3_integrator: W-bit wrapping accumulator with enable.
//   CLK     - clock, rising edge
//   reset   - asynchronous, active-low; clears the accumulator
//   en      - add addend this cycle
//   addend  - value added when en is high
//   acc_nxt - accumulator value after this cycle's addition (combinational),
//             so the next stage can cascade on the updated predecessor
`timescale 1ns/1ps
module sinc3_integrator #(
    parameter int W = 20
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] addend,
    output logic [W-1:0] acc_nxt
);
    logic [W-1:0] acc;

    // Wrap-around is intentional: the comb section recovers the exact
    // difference as long as the final result fits in W bits.
    assign acc_nxt = acc + addend;

    // NOTE: sequential state is assigned with <= so every register samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/sinc3_decimator.sv
// sinc3_decimator: third-order CIC decimator turning a 1-bit delta-sigma
// stream into OUT_W-bit signed PCM at 1/2^LOG2_OSR of the input rate.
//   CLK   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - sinc3_decimator_if.slave (bit_in, in_valid, out_data,
//           out_valid, out_sat)
// Pipeline: edge E accepts the last bit of a block and captures the updated
// third integrator; the combs run in the cycle after E; the scaled and
// saturated sample appears with out_valid on edge E+2.
// Option: define SINC3_SETTLE_EN to suppress the first two (partial)
// outputs after reset; out_data and out_sat stay 0 while suppressed.
`timescale 1ns/1ps
module sinc3_decimator
    import sinc3_pkg::*;
#(
    parameter int LOG2_OSR = LOG2_OSR_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic             CLK,
    input  logic             reset,
    sinc3_decimator_if.slave bus
);
    localparam int ACC_W = acc_w(LOG2_OSR);
    localparam int SH    = shift_amt(LOG2_OSR, OUT_W);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    if (LOG2_OSR < 2 || LOG2_OSR > 10) begin : g_bad_osr
        $error("sinc3_decimator: LOG2_OSR must be in 2..10");
    end
    if (SH < 0) begin : g_bad_out_w
        $error("sinc3_decimator: OUT_W must not exceed 3*LOG2_OSR+1");
    end

    // ------------------------------------------------------------------
    // Integrators (input rate)
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] i1_nxt;
    logic [ACC_W-1:0] i2_nxt;
    logic [ACC_W-1:0] i3_nxt;

    assign x = bus.bit_in ? ACC_W'(X_POS) : ACC_W'(X_NEG);

    sinc3_integrator #(.W(ACC_W)) u_int1 (
        .CLK     (CLK),
        .reset   (reset),
        .en      (bus.in_valid),
        .addend  (x),
        .acc_nxt (i1_nxt)
    );

    sinc3_integrator #(.W(ACC_W)) u_int2 (
        .CLK     (CLK),
        .reset   (reset),
        .en      (bus.in_valid),
        .addend  (i1_nxt),
        .acc_nxt (i2_nxt)
    );

    sinc3_integrator #(.W(ACC_W)) u_int3 (
        .CLK     (CLK),
        .reset   (reset),
        .en      (bus.in_valid),
        .addend  (i2_nxt),
        .acc_nxt (i3_nxt)
    );

    // ------------------------------------------------------------------
    // Decimation control and combs (output rate)
    // ------------------------------------------------------------------
    logic [LOG2_OSR-1:0] cnt;
    logic                capture;
    logic                cap_v;    // s holds a fresh sample; combs run now
    logic                comb_v;   // c3_q holds a fresh comb result
    logic [ACC_W-1:0]    s;
    logic [ACC_W-1:0]    d1, d2, d3;
    logic [ACC_W-1:0]    c1, c2, c3;
    logic signed [ACC_W-1:0] c3_q;

    // cnt is all ones exactly when the bit being accepted closes a block.
    assign capture = bus.in_valid && (&cnt);

    assign c1 = s  - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // NOTE: every register here, including the comb delay line, is cleared
    // by reset so a reset mid-block leaves no stale history or pending strobe.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            cap_v  <= 1'b0;
            comb_v <= 1'b0;
            s      <= '0;
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            c3_q   <= '0;
        end else begin
            cap_v  <= capture;
            comb_v <= cap_v;
            if (bus.in_valid) begin
                cnt <= cnt + 1'b1;
            end
            if (capture) begin
                s <= i3_nxt;
            end
            if (cap_v) begin
                d1   <= s;
                d2   <= c1;
                d3   <= c2;
                c3_q <= c3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scaling and saturation
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        sat_data;
    logic                    sat_flag;

    assign shifted = c3_q >>> SH;

    // NOTE: both outputs get a default first, so no path leaves them
    // unassigned and no latch is inferred.
    always_comb begin
        sat_data = shifted[OUT_W-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_data = OUT_W'(SAT_MAX);
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_data = OUT_W'(SAT_MIN);
            sat_flag = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register, optionally gated by the settle counter
    // ------------------------------------------------------------------
    logic publish;

`ifdef SINC3_SETTLE_EN
    // Counts decimated outputs after reset and saturates at 2; the first two
    // outputs are built from a partially filled delay line.
    logic [1:0] settle_cnt;

    assign publish = comb_v && (settle_cnt == 2'd2);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            settle_cnt <= 2'd0;
        end else if (comb_v && (settle_cnt != 2'd2)) begin
            settle_cnt <= settle_cnt + 2'd1;
        end
    end
`else
    assign publish = comb_v;
`endif

    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_sat_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= publish;
            if (publish) begin
                out_data_q <= sat_data;
                out_sat_q  <= sat_flag;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sinc3_decimator.sv
// tb_sinc3_decimator: self-checking bench for sinc3_decimator (defaults
// LOG2_OSR=6, OUT_W=16). The reference model treats the filter as a
// 190-tap FIR whose kernel is three 64-sample boxes convolved together,
// applied to the accepted bits since reset, then shifted and saturated.
// Honours SINC3_SETTLE_EN the same way the design does.
`timescale 1ns/1ps
module tb_sinc3_decimator;
    localparam int LOG2_OSR = 6;
    localparam int OSR      = 1 << LOG2_OSR;
    localparam int OUT_W    = 16;
    localparam int SH       = 3 * LOG2_OSR + 1 - OUT_W;
    localparam int HL       = 3 * (OSR - 1) + 1;
    localparam int YMAX     = (1 << (OUT_W - 1)) - 1;
    localparam int YMIN     = -(1 << (OUT_W - 1));
`ifdef SINC3_SETTLE_EN
    localparam int SKIP = 2;
`else
    localparam int SKIP = 0;
`endif

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    sinc3_decimator_if #(.OUT_W(OUT_W)) bus ();

    sinc3_decimator #(.LOG2_OSR(LOG2_OSR), .OUT_W(OUT_W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int h [HL];
    int xh[HL];      // ring of the last HL accepted samples as +1/-1
    int n    = 0;    // samples accepted since reset
    int nout = 0;    // decimated outputs produced since reset
    int cyc  = 0;

    typedef struct {
        int cyc;
        int data;
        bit sat;
    } exp_t;
    exp_t q[$];

    function automatic void build_kernel();
        int h2[2*OSR-1];
        for (int i = 0; i < 2*OSR-1; i++) begin
            h2[i] = 0;
            for (int j = 0; j < OSR; j++)
                if (i - j >= 0 && i - j < OSR) h2[i] += 1;
        end
        for (int i = 0; i < HL; i++) begin
            h[i] = 0;
            for (int j = 0; j < OSR; j++)
                if (i - j >= 0 && i - j < 2*OSR-1) h[i] += h2[i-j];
        end
    endfunction

    function automatic int model_out();
        int acc = 0;
        for (int k = 0; k < HL; k++)
            if (k < n) acc += h[k] * xh[(n - 1 - k) % HL];
        return acc;
    endfunction

    function automatic void scale(input int y, output int d, output bit s);
        int v = y >>> SH;
        d = v;
        s = 1'b0;
        if (v > YMAX) begin d = YMAX; s = 1'b1; end
        else if (v < YMIN) begin d = YMIN; s = 1'b1; end
    endfunction

    // Model input side: observe what the DUT accepts on each rising edge.
    always @(posedge CLK) begin
        int yd;
        bit ys;
        cyc++;
        if (!reset) begin
            n    = 0;
            nout = 0;
            q.delete();
        end else if (bus.in_valid) begin
            xh[n % HL] = bus.bit_in ? 1 : -1;
            n++;
            if (n % OSR == 0) begin
                nout++;
                if (nout > SKIP) begin
                    scale(model_out(), yd, ys);
                    q.push_back('{cyc + 2, yd, ys});
                end
            end
        end
    end

    // Compare process: every falling edge.
    int held_d = 0;
    bit held_s = 1'b0;
    bit ev;
    int strobes = 0;
    int last_strobe_cyc = 0;
    int gap = 0;
    int last_d = 0;
    int last_s = 0;
    int slog[$];

    always @(negedge CLK) begin
        ev = 1'b0;
        if (!reset) begin
            held_d = 0;
            held_s = 1'b0;
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            ev     = 1'b1;
            held_d = q[0].data;
            held_s = q[0].sat;
            void'(q.pop_front());
        end
        check("out_valid", 32'(bus.out_valid), 32'(ev));
        check("out_data", 32'(bus.out_data), held_d);
        check("out_sat", 32'(bus.out_sat), 32'(held_s));
        if (bus.out_valid === 1'b1) begin
            gap             = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
            last_d          = 32'(bus.out_data);
            last_s          = 32'(bus.out_sat);
            strobes++;
            slog.push_back(32'(bus.out_data));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic b, input logic v);
        bus.bit_in   = b;
        bus.in_valid = v;
        @(posedge CLK);
        #1;
    endtask

    // pat: 0 ones, 1 zeros, 2 1,0,..., 3 1,0,0,0,..., other random bits
    task automatic run_bits(input int pat, input int nbits, input bit rnd_valid);
        int   acc   = 0;
        int   guard = 0;
        logic b;
        logic v;
        while (acc < nbits && guard < nbits * 40) begin
            v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            case (pat)
                0:       b = 1'b1;
                1:       b = 1'b0;
                2:       b = (acc % 2 == 0);
                3:       b = (acc % 4 == 0);
                default: b = 1'($urandom_range(0, 1));
            endcase
            drive(b, v);
            if (v) acc++;
            guard++;
        end
        if (acc < nbits) check("phase_cycle_budget", acc, nbits);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0);
    endtask

    initial begin
        int s0;
        int pd;
        bit ps;
        int hsum;

        bus.bit_in   = 1'b0;
        bus.in_valid = 1'b0;
        build_kernel();

        // Pin the model with hand-computed values.
        hsum = 0;
        for (int k = 0; k < OSR; k++) hsum += h[k];
        check("pin_first_block_i3", hsum, 45760);
        scale(hsum, pd, ps);
        check("pin_partial_scaled", pd, 5720);
        hsum = 0;
        for (int k = 0; k < HL; k++) hsum += h[k];
        check("pin_gain", hsum, 262144);
        scale(262144, pd, ps);
        check("pin_pos_fullscale", pd, 32767);
        check("pin_pos_fullscale_sat", 32'(ps), 1);
        scale(-262144, pd, ps);
        check("pin_neg_fullscale", pd, -32768);
        check("pin_neg_fullscale_sat", 32'(ps), 0);
        scale(-131072, pd, ps);
        check("pin_quarter_density", pd, -16384);

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_data", 32'(bus.out_data), 0);
        check("reset_out_sat", 32'(bus.out_sat), 0);
        reset = 1'b1;
        idle(2);

        // All ones, continuous.
        s0 = strobes;
        run_bits(0, 6 * OSR, 1'b0);
        idle(3);
        check("ones_data", last_d, 32767);
        check("ones_sat", last_s, 1);
        check("ones_strobe_gap", gap, OSR);
        check("ones_strobe_count", strobes - s0, 6 - SKIP);

        run_bits(1, 4 * OSR, 1'b0);
        idle(3);
        check("zeros_data", last_d, -32768);
        check("zeros_sat", last_s, 0);

        run_bits(2, 4 * OSR, 1'b0);
        idle(3);
        check("alt_data", last_d, 0);

        run_bits(3, 4 * OSR, 1'b0);
        idle(3);
        check("q1000_data", last_d, -16384);

        // All ones with in_valid at 50%.
        s0 = strobes;
        run_bits(0, 5 * OSR, 1'b1);
        idle(3);
        check("gated_ones_data", last_d, 32767);
        check("gated_ones_sat", last_s, 1);
        check("gated_strobe_count", strobes - s0, 5);

        // Reset at accepted bit 40 of the second block.
        run_bits(0, OSR + 40, 1'b0);
        reset = 1'b0;
        #3;
        check("midreset_out_valid", 32'(bus.out_valid), 0);
        check("midreset_out_data", 32'(bus.out_data), 0);
        check("midreset_out_sat", 32'(bus.out_sat), 0);
        idle(1);
        reset = 1'b1;
        s0 = strobes;
        slog.delete();
        run_bits(0, 3 * OSR, 1'b0);
        idle(3);
        check("post_reset_strobes", strobes - s0, 3 - SKIP);
        if (slog.size() > 0)
            check("post_reset_first", slog[0], (SKIP > 0) ? 32767 : 5720);
        else
            check("post_reset_first_present", 0, 1);

        // Reset one edge after a capture: the pending sample must not strobe.
        run_bits(0, OSR, 1'b0);
        reset = 1'b0;
        s0 = strobes;
        idle(1);
        reset = 1'b1;
        idle(5);
        check("pending_capture_dropped", strobes - s0, 0);

        // Random bits with random in_valid.
        s0 = strobes;
        run_bits(4, 10 * OSR, 1'b1);
        idle(3);
        check("random_strobe_count", strobes - s0, 10 - SKIP);

        // Long all-ones run: the integrators wrap many times.
        s0 = strobes;
        run_bits(0, 500 * OSR, 1'b0);
        idle(3);
        check("long_ones_data", last_d, 32767);
        check("long_ones_sat", last_s, 1);
        check("long_strobe_count", strobes - s0, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
